// File: rtl/apb_rmw_pkg.sv
// Shared types for the APB read-modify-write master: op codes and FSM states.
package apb_rmw_pkg;

  localparam logic [1:0] OP_READ_ENC    = 2'b00;
  localparam logic [1:0] OP_WRITE_ENC   = 2'b01;
  localparam logic [1:0] OP_RMW_ADD_ENC = 2'b10;
  localparam logic [1:0] OP_RMW_SUB_ENC = 2'b11;

  typedef enum logic [1:0] {
    OP_READ    = OP_READ_ENC,
    OP_WRITE   = OP_WRITE_ENC,
    OP_RMW_ADD = OP_RMW_ADD_ENC,
    OP_RMW_SUB = OP_RMW_SUB_ENC
  } apb_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } apb_rmw_state_t;

endpackage

// File: rtl/apb_rmw_if.sv
// Request/response and APB bus bundle for apb_rmw_master.
// rsp_sat_o exists only when APB_RMW_SAT_EN is defined.
interface apb_rmw_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic [1:0]        req_op_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_data_i;
  logic              rsp_valid_o;
  logic [DATA_W-1:0] rsp_data_o;
  logic              rsp_err_o;
`ifdef APB_RMW_SAT_EN
  logic              rsp_sat_o;
`endif
  logic              psel_o;
  logic              penable_o;
  logic              pwrite_o;
  logic [ADDR_W-1:0] paddr_o;
  logic [DATA_W-1:0] pwdata_o;
  logic [DATA_W-1:0] prdata_i;
  logic              pready_i;
  logic              pslverr_i;

  modport master (
    input  req_valid_i, req_op_i, req_addr_i, req_data_i,
    input  prdata_i, pready_i, pslverr_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
    output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
`ifdef APB_RMW_SAT_EN
    , output rsp_sat_o
`endif
  );

  modport slave (
    output req_valid_i, req_op_i, req_addr_i, req_data_i,
    output prdata_i, pready_i, pslverr_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
    input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
`ifdef APB_RMW_SAT_EN
    , input rsp_sat_o
`endif
  );

endinterface

// File: rtl/apb_rmw_alu.sv
// Combinational add/sub for RMW results; wraps by default,
// saturates (all-ones / zero) with sat_o when APB_RMW_SAT_EN is defined.
module apb_rmw_alu #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              sub_i,
  output logic [DATA_W-1:0] y_o
`ifdef APB_RMW_SAT_EN
  , output logic            sat_o
`endif
);

`ifdef APB_RMW_SAT_EN
  logic [DATA_W:0] ext;

  // Top bit of the widened result is carry for ADD and borrow for SUB.
  always_comb begin
    ext   = sub_i ? ({1'b0, a_i} - {1'b0, b_i}) : ({1'b0, a_i} + {1'b0, b_i});
    sat_o = ext[DATA_W];
    if (ext[DATA_W]) y_o = sub_i ? '0 : '1;
    else             y_o = ext[DATA_W-1:0];
  end
`else
  always_comb begin
    y_o = sub_i ? (a_i - b_i) : (a_i + b_i);
  end
`endif

endmodule

// File: rtl/apb_rmw_master.sv
// APB master running READ/WRITE/RMW_ADD/RMW_SUB commands with pslverr and timeout
// handling. Optional saturating RMW arithmetic via APB_RMW_SAT_EN.
module apb_rmw_master
  import apb_rmw_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input logic        pclk,
  input logic        preset,
  apb_rmw_if.master  bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  apb_rmw_state_t    state_q, state_d;
  apb_op_t           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              pwrite_q, pwrite_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic [DATA_W-1:0] alu_y;
  logic              active;
  logic              is_rmw;
`ifdef APB_RMW_SAT_EN
  logic              sat_q, sat_d;
  logic              alu_sat;
`endif

  assign is_rmw = (op_q == OP_RMW_ADD) || (op_q == OP_RMW_SUB);

  apb_rmw_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i   (bus.prdata_i),
    .b_i   (data_q),
    .sub_i (op_q == OP_RMW_SUB),
    .y_o   (alu_y)
`ifdef APB_RMW_SAT_EN
    , .sat_o (alu_sat)
`endif
  );

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_READ;
      addr_q     <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
      pwrite_q   <= 1'b0;
      err_q      <= 1'b0;
      wait_q     <= '0;
`ifdef APB_RMW_SAT_EN
      sat_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      pwrite_q   <= pwrite_d;
      err_q      <= err_d;
      wait_q     <= wait_d;
`ifdef APB_RMW_SAT_EN
      sat_q      <= sat_d;
`endif
    end
  end

  // data_q holds the WRITE data or RMW operand, and is overwritten with the
  // RMW result once the read phase completes so the write phase drives it.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    pwrite_d   = pwrite_q;
    err_d      = err_q;
    wait_d     = wait_q;
`ifdef APB_RMW_SAT_EN
    sat_d      = sat_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid_i) begin
          op_d       = apb_op_t'(bus.req_op_i);
          addr_d     = bus.req_addr_i;
          data_d     = bus.req_data_i;
          pwrite_d   = (apb_op_t'(bus.req_op_i) == OP_WRITE);
          err_d      = 1'b0;
          rsp_data_d = '0;
          wait_d     = '0;
`ifdef APB_RMW_SAT_EN
          sat_d      = 1'b0;
`endif
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        wait_d  = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (bus.pready_i) begin
          if (!pwrite_q && is_rmw && !bus.pslverr_i) begin
            data_d   = alu_y;
            pwrite_d = 1'b1;
`ifdef APB_RMW_SAT_EN
            sat_d    = alu_sat;
`endif
            state_d  = ST_SETUP;
          end else begin
            err_d = bus.pslverr_i;
`ifdef APB_RMW_SAT_EN
            if (sat_q) err_d = 1'b0;
`endif
            if (!pwrite_q)              rsp_data_d = bus.prdata_i;
            else if (op_q == OP_WRITE)  rsp_data_d = '0;
            else                        rsp_data_d = data_q;
            state_d = ST_RESP;
          end
        end else if (wait_q == CNT_W'(TIMEOUT - 1)) begin
          err_d      = 1'b1;
          rsp_data_d = '0;
`ifdef APB_RMW_SAT_EN
          sat_d      = 1'b0;
`endif
          state_d    = ST_RESP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign active          = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign bus.req_ready_o = (state_q == ST_IDLE);
  assign bus.psel_o      = active;
  assign bus.penable_o   = (state_q == ST_ACCESS);
  assign bus.pwrite_o    = active && pwrite_q;
  assign bus.paddr_o     = active ? addr_q : '0;
  assign bus.pwdata_o    = (active && pwrite_q) ? data_q : '0;
  assign bus.rsp_valid_o = (state_q == ST_RESP);
  assign bus.rsp_data_o  = (state_q == ST_RESP) ? rsp_data_q : '0;
  assign bus.rsp_err_o   = (state_q == ST_RESP) && err_q;
`ifdef APB_RMW_SAT_EN
  assign bus.rsp_sat_o   = (state_q == ST_RESP) && sat_q;
`endif

endmodule

// File: tb/tb_apb_rmw_master.sv
// Directed bench for apb_rmw_master: vector table plus reset and back-to-back sequences.
module tb_apb_rmw_master;
  import apb_rmw_pkg::*;

  logic pclk = 1'b0;
  logic preset;
  int   checks = 0;
  int   errors = 0;

  always #5 pclk = ~pclk;

  apb_rmw_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  apb_rmw_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    int          waits;
    logic        err_rd;
    logic        err_wr;
    int          lat;
    logic [31:0] rsp;
    logic        err;
    logic        wr;
    logic [31:0] wdata;
    logic        sat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(logic [1:0] op, logic [31:0] addr, logic [31:0] data,
                              logic [31:0] rdata, int waits, logic err_rd, logic err_wr,
                              int lat, logic [31:0] rsp, logic err, logic wr,
                              logic [31:0] wdata, logic sat);
    vec_t v;
    v.op = op; v.addr = addr; v.data = data; v.rdata = rdata; v.waits = waits;
    v.err_rd = err_rd; v.err_wr = err_wr; v.lat = lat; v.rsp = rsp; v.err = err;
    v.wr = wr; v.wdata = wdata; v.sat = sat;
    return v;
  endfunction

  task automatic idle_bus();
    bus.req_valid_i = 1'b0;
    bus.req_op_i    = '0;
    bus.req_addr_i  = '0;
    bus.req_data_i  = '0;
    bus.prdata_i    = '0;
    bus.pready_i    = 1'b0;
    bus.pslverr_i   = 1'b0;
  endtask

  // Issues one command and plays the APB slave; every output seen is judged
  // against the vector's hand-computed expectations.
  task automatic run(input int idx, input vec_t v);
    int          lat = 0;
    int          wcnt = 0;
    int          bad_addr = 0;
    int          bad_proto = 0;
    logic        done = 1'b0;
    logic        wrote = 1'b0;
    logic [31:0] wseen = '0;
    logic [31:0] rdat = '0;
    logic        rerr = 1'b0;
    logic        rsat = 1'b0;
    @(negedge pclk);
    chk($sformatf("v%0d_ready", idx), {63'd0, bus.req_ready_o}, 64'd1);
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = v.op;
    bus.req_addr_i  = v.addr;
    bus.req_data_i  = v.data;
    while (!done && lat < 60) begin
      @(negedge pclk);
      lat++;
      bus.req_valid_i = 1'b0;
      bus.pready_i    = 1'b0;
      bus.pslverr_i   = 1'b0;
      bus.prdata_i    = '0;
      if (bus.rsp_valid_o) begin
        done = 1'b1;
        rdat = bus.rsp_data_o;
        rerr = bus.rsp_err_o;
`ifdef APB_RMW_SAT_EN
        rsat = bus.rsp_sat_o;
`endif
      end
      if (bus.psel_o && bus.paddr_o !== v.addr) bad_addr++;
      if (bus.psel_o && !bus.pwrite_o && bus.pwdata_o !== 32'd0) bad_proto++;
      if (!bus.psel_o && (bus.penable_o || bus.paddr_o !== 32'd0)) bad_proto++;
      if (bus.psel_o && !bus.penable_o) wcnt = 0;
      if (bus.psel_o && bus.penable_o) begin
        if (bus.pwrite_o) begin
          wrote = 1'b1;
          wseen = bus.pwdata_o;
        end
        if (wcnt < v.waits) begin
          wcnt++;
        end else begin
          bus.pready_i  = 1'b1;
          bus.prdata_i  = v.rdata;
          bus.pslverr_i = bus.pwrite_o ? v.err_wr : v.err_rd;
        end
      end
    end
    chk($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.lat));
    chk($sformatf("v%0d_rsp_data", idx), {32'd0, rdat}, {32'd0, v.rsp});
    chk($sformatf("v%0d_rsp_err", idx), {63'd0, rerr}, {63'd0, v.err});
    chk($sformatf("v%0d_write_phase", idx), {63'd0, wrote}, {63'd0, v.wr});
    if (v.wr) chk($sformatf("v%0d_pwdata", idx), {32'd0, wseen}, {32'd0, v.wdata});
    chk($sformatf("v%0d_paddr_stable", idx), 64'(bad_addr), 64'd0);
    chk($sformatf("v%0d_protocol", idx), 64'(bad_proto), 64'd0);
`ifdef APB_RMW_SAT_EN
    chk($sformatf("v%0d_rsp_sat", idx), {63'd0, rsat}, {63'd0, v.sat});
`else
    rsat = v.sat;
`endif
    idle_bus();
  endtask

  task automatic reset_mid_access();
    @(negedge pclk);
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = OP_READ;
    bus.req_addr_i  = 32'h0000_C000;
    @(negedge pclk);
    bus.req_valid_i = 1'b0;
    @(negedge pclk);
    chk("rst_pre_psel", {62'd0, bus.psel_o, bus.penable_o}, 64'd3);
    #2 preset = 1'b1;
    #1;
    chk("rst_async_apb", {29'd0, bus.psel_o, bus.penable_o, bus.pwrite_o, bus.rsp_valid_o,
                          (bus.paddr_o != 32'd0)}, 64'd0);
    chk("rst_async_ready", {63'd0, bus.req_ready_o}, 64'd1);
    @(negedge pclk);
    preset = 1'b0;
    @(negedge pclk);
    chk("rst_release", {61'd0, bus.req_ready_o, bus.psel_o, bus.rsp_valid_o}, 64'd4);
  endtask

  task automatic back_to_back();
    int   acc_n = 0;
    int   acc2 = -1;
    int   rsp1 = -1;
    int   rsp2 = -1;
    int   bad = 0;
    logic [31:0] r2 = '0;
    bus.pready_i  = 1'b1;
    bus.prdata_i  = 32'hCAFE_0000;
    @(negedge pclk);
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = OP_WRITE;
    bus.req_addr_i  = 32'h0000_B000;
    bus.req_data_i  = 32'h0000_1111;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge pclk);
      if (acc_n == 1 && bus.req_op_i == OP_WRITE) begin
        bus.req_op_i   = OP_READ;
        bus.req_addr_i = 32'h0000_B004;
        bus.req_data_i = 32'h0000_2222;
      end
      if (acc_n == 2) bus.req_valid_i = 1'b0;
      if (bus.psel_o) begin
        if (acc_n == 1 && (bus.paddr_o !== 32'h0000_B000 || bus.pwdata_o !== 32'h0000_1111
                           || !bus.pwrite_o)) bad++;
        if (acc_n == 2 && (bus.paddr_o !== 32'h0000_B004 || bus.pwdata_o !== 32'd0
                           || bus.pwrite_o)) bad++;
      end
      if (bus.rsp_valid_o) begin
        if (rsp1 < 0) rsp1 = c;
        else begin rsp2 = c; r2 = bus.rsp_data_o; end
      end
      if (bus.req_ready_o && bus.req_valid_i) begin
        acc_n++;
        if (acc_n == 2) acc2 = c;
      end
    end
    chk("b2b_rsp1_cycle", 64'(rsp1), 64'd3);
    chk("b2b_accept2_cycle", 64'(acc2), 64'd4);
    chk("b2b_rsp2_cycle", 64'(rsp2), 64'd7);
    chk("b2b_rsp2_data", {32'd0, r2}, 64'h0000_0000_CAFE_0000);
    chk("b2b_stable", 64'(bad), 64'd0);
    idle_bus();
  endtask

  initial begin
    vecs[0]  = mk(OP_READ,    32'h0000_A000, 32'h0,          32'h1234_5678, 0,    0, 0, 3,  32'h1234_5678, 0, 0, 32'h0,          0);
    vecs[1]  = mk(OP_WRITE,   32'h0000_A004, 32'hDEAD_BEEF,  32'h0,         0,    0, 0, 3,  32'h0,         0, 1, 32'hDEAD_BEEF,  0);
    vecs[2]  = mk(OP_RMW_ADD, 32'h0000_A000, 32'h1,          32'hFFFF_FFFF, 2,    0, 0, 9,  32'h0,         0, 1, 32'h0,          0);
    vecs[3]  = mk(OP_RMW_SUB, 32'h0000_A008, 32'h5,          32'h10,        0,    0, 0, 5,  32'hB,         0, 1, 32'hB,          0);
    vecs[4]  = mk(OP_RMW_SUB, 32'h0000_A00C, 32'h1,          32'h0,         1,    0, 0, 7,  32'hFFFF_FFFF, 0, 1, 32'hFFFF_FFFF,  0);
    vecs[5]  = mk(OP_RMW_SUB, 32'h0000_A010, 32'h3,          32'h55,        0,    1, 0, 3,  32'h55,        1, 0, 32'h0,          0);
    vecs[6]  = mk(OP_READ,    32'h0000_A014, 32'h0,          32'h77,        3,    1, 0, 6,  32'h77,        1, 0, 32'h0,          0);
    vecs[7]  = mk(OP_WRITE,   32'h0000_A018, 32'h0BAD_F00D,  32'h0,         0,    0, 1, 3,  32'h0,         1, 1, 32'h0BAD_F00D,  0);
    vecs[8]  = mk(OP_RMW_ADD, 32'h0000_A01C, 32'h23,         32'h100,       0,    0, 1, 5,  32'h123,       1, 1, 32'h123,        0);
    vecs[9]  = mk(OP_WRITE,   32'h0000_A020, 32'h5A5A_5A5A,  32'h0,         1000, 0, 0, 18, 32'h0,         1, 1, 32'h5A5A_5A5A,  0);
    vecs[10] = mk(OP_READ,    32'h0000_A024, 32'h0,          32'h0F0F_0F0F, 15,   0, 0, 18, 32'h0F0F_0F0F, 0, 0, 32'h0,          0);
    vecs[11] = mk(OP_RMW_ADD, 32'h0000_A028, 32'h1,          32'h7FFF_FFFF, 0,    0, 0, 5,  32'h8000_0000, 0, 1, 32'h8000_0000,  0);
`ifdef APB_RMW_SAT_EN
    vecs[2].rsp = 32'hFFFF_FFFF; vecs[2].wdata = 32'hFFFF_FFFF; vecs[2].sat = 1'b1;
    vecs[4].rsp = 32'h0;         vecs[4].wdata = 32'h0;         vecs[4].sat = 1'b1;
`endif

    idle_bus();
    preset = 1'b1;
    #12;
    chk("reset_ready", {63'd0, bus.req_ready_o}, 64'd1);
    chk("reset_outputs", {59'd0, bus.psel_o, bus.penable_o, bus.pwrite_o, bus.rsp_valid_o,
                          bus.rsp_err_o}, 64'd0);
    chk("reset_buses", {bus.paddr_o, bus.pwdata_o | bus.rsp_data_o}, 64'd0);
    @(negedge pclk);
    preset = 1'b0;

    for (int i = 0; i < 12; i++) run(i, vecs[i]);
    reset_mid_access();
    back_to_back();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_rmw_master.md
Name: apb_rmw_master

Overview:
- Parametrised APB (AMBA3-style) master.
- Accepts one command at a time over a valid/ready request port: READ, WRITE, RMW_ADD or RMW_SUB at a programmable address.
- Drives the APB transfer or transfers, then returns one response pulse carrying read data or the RMW result, plus an error flag.
- Sits between local control logic and the APB peripheral bus. Generalises the fixed-address increment master to arbitrary address, operand, width and operation, and adds error handling and timeout.

Parameters:
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width and operand width.
- TIMEOUT, 16, maximum ACCESS cycles per transfer with pready_i low before abort (must be ≥1).

Ports:
- pclk  in  1  clock. One clock; all logic on its rising edge.
- preset  in  1  reset. Asynchronous, active-high.
- req_valid_i  in  1  command valid.
- req_ready_o  out  1  command accepted when valid & ready.
- req_op_i  in  2  2'b00 READ, 2'b01 WRITE, 2'b10 RMW_ADD, 2'b11 RMW_SUB.
- req_addr_i  in  ADDR_W  target address.
- req_data_i  in  DATA_W  write data (WRITE) or operand (RMW).
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_data_o  out  DATA_W  READ: read data; RMW: value written; WRITE: 0.
- rsp_err_o  out  1  pslverr or timeout occurred.
- psel_o, penable_o, pwrite_o  out  1  APB controls.
- paddr_o  out  ADDR_W  APB address.
- pwdata_o  out  DATA_W  APB write data.
- prdata_i  in  DATA_W  APB read data.
- pready_i  in  1  APB ready.
- pslverr_i  in  1  APB slave error.

Behaviour:
- Reset (async, any state): FSM goes to IDLE; all outputs 0 except req_ready_o=1; all internal registers 0.
- States: IDLE, SETUP, ACCESS, RESP.
- req_ready_o=1 only in IDLE.
- On accept, latch op, addr and data. Next state is SETUP with pwrite = (op==WRITE). Phase flag = READ phase for READ/RMW.
- SETUP: psel=1, penable=0 for exactly 1 cycle, then ACCESS.
- ACCESS: psel=1, penable=1. Wait counter starts at 0 and increments each cycle pready_i=0.
- If pready_i=1:
  - Capture prdata_i on a read; capture pslverr_i.
  - RMW read phase without error: compute result, set pwrite=1, go to SETUP (write phase).
  - Otherwise go to RESP.
- If the counter reaches TIMEOUT with pready_i still 0: set err=1, go to RESP. psel/penable drop next cycle; rsp_data_o=0.
- RMW read phase with pslverr: skip the write phase. Respond err=1, rsp_data_o = read data.
- RESP: rsp_valid_o=1 for exactly 1 cycle, then IDLE. rsp_data_o and rsp_err_o are valid only while rsp_valid_o=1, else 0.
- paddr_o and pwdata_o are driven with latched values during SETUP/ACCESS and are 0 in IDLE/RESP. They are stable across the whole transfer. pwdata_o=0 during read phases.
- pwrite_o is constant within a transfer.
- Arithmetic: ADD = rdata + operand mod 2^DATA_W; SUB = rdata − operand mod 2^DATA_W.
- Latency with zero wait states, counted from the accept edge:
  - READ/WRITE: rsp_valid_o high on cycle 3 (SETUP c1, ACCESS c2, RESP c3).
  - RMW: RESP on cycle 5.
- Each wait state adds 1 cycle per transfer.
- req_valid_i while not ready is ignored; the requester must hold it.
- Back-to-back: the earliest next accept is the cycle after RESP. psel_o is low for ≥2 cycles (RESP + IDLE) between commands; within an RMW, psel_o stays high across the read→write boundary (ACCESS→SETUP).
- pslverr_i is sampled only when penable & pready.

Optional Feature:
- APB_RMW_SAT_EN defined: RMW results saturate instead of wrapping.
  - ADD overflow clamps to all-ones.
  - SUB underflow clamps to 0.
  - A clamp event also sets rsp_err_o=0 and drives an extra output rsp_sat_o=1 in the RESP cycle.
- Not defined: wrap-around arithmetic; rsp_sat_o does not exist.

Decomposition:
- apb_rmw_pkg holds:
  - typedef enum logic[1:0] apb_op_t (OP_READ, OP_WRITE, OP_RMW_ADD, OP_RMW_SUB);
  - typedef enum apb_rmw_state_t (ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP);
  - localparam OP encodings.
- One sub-module, apb_rmw_alu: combinational add/sub with DATA_W parameter. It contains the APB_RMW_SAT_EN saturation logic and its sat flag.

Test Plan:
- Reset mid-ACCESS (assert preset with psel=1) → all APB outputs 0 immediately (async), req_ready_o=1 after release.
- READ addr 0x0000_A000, slave returns 0x1234_5678 with 0 waits → psel rises cycle 1, penable cycle 2, rsp_valid cycle 3, rsp_data=0x1234_5678, err=0.
- RMW_ADD addr 0xA000 operand 1, slave holds 0xFFFF_FFFF, 2 wait states on each phase → write phase pwdata=0x0000_0000 (wrap; with APB_RMW_SAT_EN: 0xFFFF_FFFF and rsp_sat_o=1), rsp_valid on cycle 9.
- RMW_SUB with pslverr on read → no write transfer (pwrite_o never 1), rsp_err=1, rsp_data = read value.
- WRITE with pready_i held low, TIMEOUT=16 → abort after 16 ACCESS cycles, rsp_err=1, psel drops, req_ready_o returns 1.
- Back-to-back WRITE then READ with req_valid_i held high → second accept the cycle after first RESP; paddr_o and pwdata_o stable throughout each transfer.
